// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one
// operation in flight, result held per owner until the owner consumes it.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             owner;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             grant0;
    logic             grant1;
    logic             owner_ready;

    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    // Next state and grant; grants are only ever raised in IDLE
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                grant1 = req1_valid && (!req0_valid || prio);
                grant0 = req0_valid && !grant1;
                if (grant0 || grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_r     <= 3'b000;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                owner <= grant1;
                prio  <= !grant1;
                op_r  <= grant1 ? req1_op : req0_op;
                a_r   <= grant1 ? req1_a  : req0_a;
                b_r   <= grant1 ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                result_r <= alu_result;
                zero_r   <= alu_zero;
            end
        end
    end

    // Ready is masked by rst so nothing is offered while reset is held
    assign req0_ready  = grant0 && !rst;
    assign req1_ready  = grant1 && !rst;

    assign rsp0_valid  = (state == RESP) && !owner;
    assign rsp1_valid  = (state == RESP) && owner;
    assign rsp0_result = result_r;
    assign rsp1_result = result_r;
    assign rsp0_zero   = zero_r;
    assign rsp1_zero   = zero_r;

    assign alu_srca    = a_r;
    assign alu_srcb    = b_r;
    assign alu_control = op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op [2];
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result [2];
    logic [1:0]       rsp_zero;
    logic [WIDTH-1:0] alu_srca;
    logic [WIDTH-1:0] alu_srcb;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req_ready[0]),
        .req0_op     (req_op[0]),
        .req0_a      (req_a[0]),
        .req0_b      (req_b[0]),
        .rsp0_valid  (rsp_valid[0]),
        .rsp0_ready  (rsp_ready[0]),
        .rsp0_result (rsp_result[0]),
        .rsp0_zero   (rsp_zero[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req_ready[1]),
        .req1_op     (req_op[1]),
        .req1_a      (req_a[1]),
        .req1_b      (req_b[1]),
        .rsp1_valid  (rsp_valid[1]),
        .rsp1_ready  (rsp_ready[1]),
        .rsp1_result (rsp_result[1]),
        .rsp1_zero   (rsp_zero[1]),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Shared ALU model (MIPS-style ALUControl encoding)
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_srca & alu_srcb;
            3'b001:  alu_result = alu_srca | alu_srcb;
            3'b010:  alu_result = alu_srca + alu_srcb;
            3'b110:  alu_result = alu_srca - alu_srcb;
            3'b111:  alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? WIDTH'(1) : WIDTH'(0);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (alu_control !== 3'b000) begin errors++; $display("FAIL reset_alu_control: got %b expected 000", alu_control); end
        checks++; if (alu_srca !== '0 || alu_srcb !== '0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", alu_srca, alu_srcb); end
        checks++; if (rsp_result[0] !== '0 || rsp_result[1] !== '0) begin errors++; $display("FAIL reset_result: got %h/%h expected 0/0", rsp_result[0], rsp_result[1]); end
        checks++; if (rsp_zero !== 2'b00) begin errors++; $display("FAIL reset_zero: got %b expected 00", rsp_zero); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_release_ready: got %b expected 01", req_ready); end
        req_valid = 2'b00;
    endtask

    // One isolated operation by requester id; the other requester stays idle
    task automatic run_op(input int id, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_r,
                          input logic exp_z, input string tag);
        logic [1:0] sel;
        sel = (id == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_op[id] = op;
        req_a[id] = a;
        req_b[id] = b;
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== sel) begin errors++; $display("FAIL %s_ready: got %b expected %b", tag, req_ready, sel); end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        checks++; if (alu_srca !== a || alu_srcb !== b || alu_control !== op) begin
            errors++; $display("FAIL %s_exec: got %h/%h/%b expected %h/%h/%b", tag, alu_srca, alu_srcb, alu_control, a, b, op);
        end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL %s_exec_valid: got %b expected 00", tag, rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== sel) begin errors++; $display("FAIL %s_rsp_valid: got %b expected %b", tag, rsp_valid, sel); end
        checks++; if (rsp_result[id] !== exp_r) begin errors++; $display("FAIL %s_result: got %h expected %h", tag, rsp_result[id], exp_r); end
        checks++; if (rsp_zero[id] !== exp_z) begin errors++; $display("FAIL %s_zero: got %b expected %b", tag, rsp_zero[id], exp_z); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL %s_done: got %b expected 00", tag, rsp_valid); end
    endtask

    task automatic test_single();
        run_op(0, 3'b010, 32'd0, 32'd199999, 32'd199999, 1'b0, "single");
    endtask

    task automatic test_zero_and_ops();
        run_op(0, 3'b110, 32'd5, 32'd5, 32'd0, 1'b1, "zero_sub");
        run_op(1, 3'b110, 32'd1, 32'd199999, 32'hFFFC_F2C2, 1'b0, "neg_sub");
        checks++; if (rsp_result[0] !== 32'hFFFC_F2C2 || rsp_zero[0] !== 1'b0) begin
            errors++; $display("FAIL nonowner_view: got %h/%b expected fffcf2c2/0", rsp_result[0], rsp_zero[0]);
        end
        run_op(0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt");
        run_op(1, 3'b001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, "or");
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_op[0] = 3'b010; req_a[0] = 32'd1; req_b[0] = 32'd2;
        req_op[1] = 3'b010; req_a[1] = 32'd3; req_b[1] = 32'd4;
        rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            exp_rdy = (c % 6 == 0) ? 2'b01 : (c % 6 == 3) ? 2'b10 : 2'b00;
            exp_rsp = (c % 6 == 2) ? 2'b01 : (c % 6 == 5) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready c%0d: got %b expected %b", c, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL contention_rsp c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_op[1] = 3'b010; req_a[1] = 32'd7; req_b[1] = 32'd8;
        rsp_ready = 2'b00;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_op[0] = 3'b000; req_a[0] = 32'd12; req_b[0] = 32'd10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready: got %b expected 00", req_ready); end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b10 || rsp_result[1] !== 32'd15) begin
                errors++; $display("FAIL bp_hold k%0d: got %b/%h expected 10/0000000f", k, rsp_valid, rsp_result[1]);
            end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall k%0d: got %b expected 00", k, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin
            errors++; $display("FAIL bp_release: got %b/%b expected 10/00", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL bp_accept0: got %b/%b expected 01/00", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_result[0] !== 32'd8) begin
            errors++; $display("FAIL bp_rsp0: got %b/%h expected 01/00000008", rsp_valid, rsp_result[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_op[1] = 3'b010; req_a[1] = 32'd100; req_b[1] = 32'd23;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_grant1: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b01;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rm_immediate: got %b/%b expected 00/00", rsp_valid, req_ready);
        end
        checks++; if (alu_srca !== '0 || alu_control !== 3'b000) begin
            errors++; $display("FAIL rm_operands: got %h/%b expected 0/000", alu_srca, alu_control);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || rsp_result[1] !== '0) begin
            errors++; $display("FAIL rm_abandon: got %b/%h expected 00/0", rsp_valid, rsp_result[1]);
        end
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_prio: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_rsp: got %b expected 00", rsp_valid); end
        run_op(0, 3'b010, 32'd3, 32'd4, 32'd7, 1'b0, "post_reset");
    endtask

    task automatic test_withdraw();
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_op[0] = 3'b001; req_a[0] = 32'h5; req_b[0] = 32'hA;
        rsp_ready = 2'b00;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wd_grant0: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_op[1] = 3'b010; req_a[1] = 32'd1000; req_b[1] = 32'd1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_result[0] !== 32'hF) begin
            errors++; $display("FAIL wd_resp: got %b/%b/%h expected 00/01/0000000f", req_ready, rsp_valid, rsp_result[0]);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wd_still_resp: got %b expected 01", rsp_valid); end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || alu_srca !== 32'h5) begin
                errors++; $display("FAIL wd_idle k%0d: got %b/%b/%h expected 00/00/00000005", k, rsp_valid, req_ready, alu_srca);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = 3'b000;
            req_a[i] = '0;
            req_b[i] = '0;
        end
        test_reset();
        test_single();
        test_zero_and_ops();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width.
REQ-002 The block SHALL have these ports, one clock domain; reset is asynchronous and active-high:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 operation request
req0_ready  output  1  requester 0 request accepted this cycle
req0_op  input  3  requester 0 ALUControl code
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
rsp0_valid  output  1  requester 0 result available
rsp0_ready  input  1  requester 0 consumes result
rsp0_result  output  WIDTH  requester 0 result
rsp0_zero  output  1  requester 0 zero flag
req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as requester 0, for requester 1
alu_srca  output  WIDTH  to shared ALU SrcA
alu_srcb  output  WIDTH  to shared ALU SrcB
alu_control  output  3  to shared ALU ALUControl
alu_result  input  WIDTH  from shared ALU ALUResult
alu_zero  input  1  from shared ALU zero_flag

Function
REQ-003 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-004 In IDLE, grant: one valid -> that requester; both valid -> requester holding priority; none -> no grant.
REQ-005 reqN_ready SHALL be high only in IDLE and only for the granted requester (combinational from valids and priority); never both high.
REQ-006 On accept (valid & ready), op/a/b SHALL be latched into operand registers, owner ID recorded, state -> EXEC.
REQ-007 alu_srca/alu_srcb/alu_control SHALL be driven only from operand registers (no combinational path from req ports); values hold when not in EXEC.
REQ-008 In EXEC (exactly one cycle), alu_result/alu_zero SHALL be captured at the clock edge into result registers; state -> RESP.
REQ-009 In RESP, rspN_valid SHALL be high only for the owner; rspN_result/rspN_zero SHALL show captured values and stay stable until rspN_ready.
REQ-010 RESP with owner's rsp_ready high -> IDLE next cycle; low -> remain in RESP, no new requests accepted.
REQ-011 rspN_result/rspN_zero of non-owner SHALL still show the last captured values; only rspN_valid qualifies them.
REQ-012 Priority SHALL flip to the other requester after each accept (round-robin); a single-valid grant to the non-priority requester also flips priority away from it.
REQ-013 Latency: accept at edge t -> result captured at t+1 -> rsp_valid high cycle after t+1; peak throughput one op per 3 cycles.
REQ-014 A requester dropping valid before ready SHALL not be accepted; no operation is queued.
REQ-015 op codes SHALL pass through unmodified; the block SHALL not decode them.

Reset
REQ-016 rst high SHALL immediately set: state IDLE, priority requester 0, reqN_ready 0 while rst high, rspN_valid 0, operand/result registers 0, alu_control 3'b000, rspN_zero 0.
REQ-017 rst mid-EXEC or mid-RESP SHALL abandon the operation; no response delivered after reset release.
REQ-018 First cycle after reset release SHALL be able to accept a request.

Verification
REQ-019 Single op: req0 a=0 b=199999 op=3'b010, rsp0_ready=1 -> req0_ready 1 in cycle 0; EXEC cycle alu_srca=0, alu_srcb=199999, alu_control=3'b010; rsp0_valid 1 in cycle 2 with rsp0_result = ALU model output; rsp1_valid 0 throughout.
REQ-020 Contention: req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1, each 3 cycles apart; no two ready same cycle.
REQ-021 Backpressure: rsp1_ready low 5 cycles with req0 valid -> rsp1_valid and rsp1_result stable, req0_ready 0 all 5 cycles; req0 accepted the cycle after rsp1_ready rises.
REQ-022 Zero flag: a=5 b=5 with subtract code -> rspN_zero 1; a=1 b=199999 -> rspN_zero matches ALU model.
REQ-023 Reset mid-op: rst pulse in EXEC cycle -> rsp valids 0 immediately, priority 0; next request served normally.
REQ-024 Valid withdrawn: req1 valid one cycle while in RESP for req0, then low -> no op executed for req1.
